// File: rtl/boron_key_schedule.sv
// boron_key_schedule: iterative BORON round-key generator.
// Emits RK_0..RK_ROUNDS in encryption order or reversed for decryption.

module boron_sbox (
    input  logic [3:0] x,
    output logic [3:0] y
);
    always_comb begin
        unique case (x)
            4'h0: y = 4'hE;
            4'h1: y = 4'h4;
            4'h2: y = 4'hB;
            4'h3: y = 4'h1;
            4'h4: y = 4'h7;
            4'h5: y = 4'h9;
            4'h6: y = 4'hC;
            4'h7: y = 4'hA;
            4'h8: y = 4'hD;
            4'h9: y = 4'h2;
            4'hA: y = 4'h0;
            4'hB: y = 4'hF;
            4'hC: y = 4'h8;
            4'hD: y = 4'h5;
            4'hE: y = 4'h3;
            default: y = 4'h6;
        endcase
    end
endmodule

module boron_sbox_inv (
    input  logic [3:0] x,
    output logic [3:0] y
);
    always_comb begin
        unique case (x)
            4'h0: y = 4'hA;
            4'h1: y = 4'h3;
            4'h2: y = 4'h9;
            4'h3: y = 4'hE;
            4'h4: y = 4'h1;
            4'h5: y = 4'hD;
            4'h6: y = 4'hF;
            4'h7: y = 4'h4;
            4'h8: y = 4'hC;
            4'h9: y = 4'h5;
            4'hA: y = 4'h7;
            4'hB: y = 4'h2;
            4'hC: y = 4'h6;
            4'hD: y = 4'h8;
            4'hE: y = 4'h0;
            default: y = 4'hB;
        endcase
    end
endmodule

module boron_key_schedule #(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [KEY_W-1:0] key_in,
    input  logic             rk_ready,
    output logic             rk_valid,
    output logic [63:0]      rk_out,
    output logic [4:0]       rk_round,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        EMIT,
        FIN
    } state_t;

    localparam logic [4:0] LAST = 5'(ROUNDS);

    state_t           state;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] key_rot;
    logic [KEY_W-1:0] key_f;
    logic [KEY_W-1:0] key_x;
    logic [KEY_W-1:0] key_gp;
    logic [KEY_W-1:0] key_g;
    logic [4:0]       rnd;
    logic [4:0]       rnd_inc;
    logic             dec;
    logic             last_key;
    logic [3:0]       sf_lo;
    logic [3:0]       si_lo;

    assign rnd_inc = rnd + 5'd1;

    // Forward path: rotate first, substitute, then fold in round r = rnd+1.
    assign key_rot = {key_q[KEY_W-14:0], key_q[KEY_W-1:KEY_W-13]};

    // Inverse path: undo the round constant r = rnd before S^-1 and rotate.
    assign key_x = key_q ^ {{(KEY_W-64){1'b0}}, rnd, 59'd0};

    boron_sbox u_sf_lo (
        .x(key_rot[3:0]),
        .y(sf_lo)
    );

    boron_sbox_inv u_si_lo (
        .x(key_x[3:0]),
        .y(si_lo)
    );

    generate
        if (KEY_W == 128) begin : g_wide
            logic [3:0] sf_hi;
            logic [3:0] si_hi;

            boron_sbox u_sf_hi (
                .x(key_rot[7:4]),
                .y(sf_hi)
            );

            boron_sbox_inv u_si_hi (
                .x(key_x[7:4]),
                .y(si_hi)
            );

            assign key_f = {key_rot[KEY_W-1:64],
                            key_rot[63:59] ^ rnd_inc,
                            key_rot[58:8], sf_hi, sf_lo};
            assign key_gp = {key_x[KEY_W-1:8], si_hi, si_lo};
        end else begin : g_narrow
            assign key_f = {key_rot[KEY_W-1:64],
                            key_rot[63:59] ^ rnd_inc,
                            key_rot[58:4], sf_lo};
            assign key_gp = {key_x[KEY_W-1:4], si_lo};
        end
    endgenerate

    assign key_g = {key_gp[12:0], key_gp[KEY_W-1:13]};

    assign last_key = dec ? (rnd == 5'd0) : (rnd == LAST);

    assign rk_out   = key_q[63:0];
    assign rk_round = rnd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            key_q    <= '0;
            rnd      <= '0;
            dec      <= 1'b0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        key_q <= key_in;
                        rnd   <= '0;
                        dec   <= mode;
                        busy  <= 1'b1;
                        if (mode) begin
                            state <= EXPAND;
                        end else begin
                            state    <= EMIT;
                            rk_valid <= 1'b1;
                        end
                    end
                end
                EXPAND: begin
                    key_q <= key_f;
                    rnd   <= rnd_inc;
                    if (rnd_inc == LAST) begin
                        state    <= EMIT;
                        rk_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (last_key) begin
                            state    <= FIN;
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                        end else if (dec) begin
                            key_q <= key_g;
                            rnd   <= rnd - 5'd1;
                        end else begin
                            key_q <= key_f;
                            rnd   <= rnd_inc;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_boron_key_schedule.sv
// Scoreboard bench for boron_key_schedule: three instances
// (80/25, 128/25, 80/1) behind a shared stimulus mux.

module tb_boron_key_schedule;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [127:0] key_in = '0;
    logic         rk_ready = 1'b1;
    int           sel = 0;
    int           tests = 0;
    int           fails = 0;

    logic        a_valid, a_busy, a_done;
    logic [63:0] a_out;
    logic [4:0]  a_round;
    logic        b_valid, b_busy, b_done;
    logic [63:0] b_out;
    logic [4:0]  b_round;
    logic        c_valid, c_busy, c_done;
    logic [63:0] c_out;
    logic [4:0]  c_round;

    logic        o_valid, o_busy, o_done;
    logic [63:0] o_out;
    logic [4:0]  o_round;

    logic [63:0] exp_k [$];
    logic [4:0]  exp_r [$];
    logic [63:0] cap_q [$];

    logic [3:0] sb [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                            4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

    always #5 clk = ~clk;

    boron_key_schedule #(.KEY_W(80), .ROUNDS(25)) dut_a (
        .clk(clk), .rst(rst), .start(start && sel == 0), .mode(mode),
        .key_in(key_in[79:0]), .rk_ready(rk_ready), .rk_valid(a_valid),
        .rk_out(a_out), .rk_round(a_round), .busy(a_busy), .done(a_done)
    );

    boron_key_schedule #(.KEY_W(128), .ROUNDS(25)) dut_b (
        .clk(clk), .rst(rst), .start(start && sel == 1), .mode(mode),
        .key_in(key_in), .rk_ready(rk_ready), .rk_valid(b_valid),
        .rk_out(b_out), .rk_round(b_round), .busy(b_busy), .done(b_done)
    );

    boron_key_schedule #(.KEY_W(80), .ROUNDS(1)) dut_c (
        .clk(clk), .rst(rst), .start(start && sel == 2), .mode(mode),
        .key_in(key_in[79:0]), .rk_ready(rk_ready), .rk_valid(c_valid),
        .rk_out(c_out), .rk_round(c_round), .busy(c_busy), .done(c_done)
    );

    always_comb begin
        o_valid = a_valid;
        o_busy  = a_busy;
        o_done  = a_done;
        o_out   = a_out;
        o_round = a_round;
        if (sel == 1) begin
            o_valid = b_valid;
            o_busy  = b_busy;
            o_done  = b_done;
            o_out   = b_out;
            o_round = b_round;
        end else if (sel == 2) begin
            o_valid = c_valid;
            o_busy  = c_busy;
            o_done  = c_done;
            o_out   = c_out;
            o_round = c_round;
        end
    end

    function automatic int cur_rounds();
        return (sel == 2) ? 1 : 25;
    endfunction

    function automatic int cur_kw();
        return (sel == 1) ? 128 : 80;
    endfunction

    function automatic logic [127:0] m_f(input logic [127:0] k,
                                         input int r, input int kw);
        logic [127:0] t = '0;
        for (int i = 0; i < kw; i++) t[(i + 13) % kw] = k[i];
        t[3:0] = sb[t[3:0]];
        if (kw == 128) t[7:4] = sb[t[7:4]];
        t[63:59] = t[63:59] ^ 5'(r);
        return t;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic m, input logic [127:0] key);
        logic [127:0] ks [32];
        int r = cur_rounds();
        ks[0] = key;
        for (int i = 1; i <= r; i++) ks[i] = m_f(ks[i-1], i, cur_kw());
        for (int i = 0; i <= r; i++) begin
            int j = m ? (r - i) : i;
            exp_k.push_back(ks[j][63:0]);
            exp_r.push_back(5'(j));
        end
    endtask

    task automatic run(input string tag, input logic m,
                       input logic [127:0] key, input bit bp,
                       input bit poke, input bit rt);
        int cyc = 0;
        int dones = 0;
        int hs = 0;
        int first = -1;
        int last_hs = -1;
        int done_cyc = -1;
        int r = cur_rounds();
        bit stalled = 1'b0;
        logic [63:0] hk = '0;
        logic [4:0] hr = '0;
        if (!m) cap_q.delete();
        push_exp(m, key);
        @(negedge clk);
        mode = m;
        key_in = key;
        start = 1'b1;
        rk_ready = 1'b1;
        while (cyc < 400 && (done_cyc < 0 || cyc < done_cyc + 2)) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                check({tag, " busy_on"}, 64'(o_busy), 1);
                mode = ~m;
                key_in = ~key;
            end
            if (poke && (cyc == 3 || (m && cyc == r + 3))) start = 1'b1;
            if (stalled) begin
                check({tag, " hold_k"}, o_out, hk);
                check({tag, " hold_r"}, 64'(o_round), 64'(hr));
                check({tag, " hold_v"}, 64'(o_valid), 1);
                stalled = 1'b0;
            end
            if (o_done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check({tag, " done_lat"}, 64'(cyc), 64'(last_hs + 1));
                    check({tag, " busy_done"}, 64'(o_busy), 1);
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check({tag, " busy_off"}, 64'(o_busy), 0);
                check({tag, " done_off"}, 64'(o_done), 0);
            end
            if (o_valid && first < 0) first = cyc;
            rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_valid) begin
                if (rk_ready) begin
                    hs++;
                    last_hs = cyc;
                    if (exp_k.size() == 0) begin
                        check({tag, " extra_key"}, 64'(hs), 64'(r + 1));
                    end else begin
                        check({tag, " rk"}, o_out, exp_k.pop_front());
                        check({tag, " rnd"}, 64'(o_round),
                              64'(exp_r.pop_front()));
                    end
                    if (!m) cap_q.push_back(o_out);
                    else if (rt && cap_q.size() > 0)
                        check({tag, " roundtrip"}, o_out, cap_q.pop_back());
                end else begin
                    stalled = 1'b1;
                    hk = o_out;
                    hr = o_round;
                end
            end
        end
        check({tag, " handshakes"}, 64'(hs), 64'(r + 1));
        check({tag, " dones"}, 64'(dones), 1);
        check({tag, " first_lat"}, 64'(first), 64'(m ? r + 1 : 1));
        check({tag, " sb_left"}, 64'(exp_k.size()), 0);
        exp_k.delete();
        exp_r.delete();
        rk_ready = 1'b1;
    endtask

    initial begin
        logic [127:0] k1;
        logic [127:0] k2;
        logic [127:0] k3;
        int guard;
        k1 = {48'd0, 16'($urandom), 32'($urandom), 32'($urandom)};
        k2 = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
        k3 = {48'd0, 16'($urandom), 32'($urandom), 32'($urandom)};

        repeat (3) @(negedge clk);
        check("rst_valid", 64'(o_valid), 0);
        check("rst_out", o_out, 0);
        check("rst_round", 64'(o_round), 0);
        check("rst_busy", 64'(o_busy), 0);
        check("rst_done", 64'(o_done), 0);
        check("rst_b_valid", 64'(b_valid), 0);
        check("rst_c_valid", 64'(c_valid), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        sel = 0;
        run("enc80_zero", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("zero_rk0", cap_q[0], 64'h0);
        check("zero_rk1", cap_q[1], 64'h0800_0000_0000_000E);

        run("enc80", 1'b0, k1, 1'b0, 1'b0, 1'b0);
        run("dec80", 1'b1, k1, 1'b0, 1'b0, 1'b1);

        sel = 1;
        run("enc128", 1'b0, k2, 1'b0, 1'b0, 1'b0);
        run("dec128", 1'b1, k2, 1'b0, 1'b0, 1'b1);
        run("dec128_bp", 1'b1, k2, 1'b1, 1'b0, 1'b0);

        sel = 0;
        run("enc80_bp", 1'b0, k1, 1'b1, 1'b0, 1'b0);
        run("dec80_bp", 1'b1, k1, 1'b1, 1'b0, 1'b1);
        run("dec80_poke", 1'b1, k3, 1'b0, 1'b1, 1'b0);
        run("enc80_poke", 1'b0, k3, 1'b0, 1'b1, 1'b0);

        // Abort a schedule at RK_7 with an asynchronous reset.
        @(negedge clk);
        mode = 1'b0;
        key_in = k1;
        start = 1'b1;
        rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(o_valid && o_round == 5'd7) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("mid_reach7", 64'(o_round), 7);
        #2 rst = 1'b0;
        #1;
        check("mid_valid", 64'(o_valid), 0);
        check("mid_out", o_out, 0);
        check("mid_round", 64'(o_round), 0);
        check("mid_busy", 64'(o_busy), 0);
        check("mid_done", 64'(o_done), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post_valid", 64'(o_valid), 0);
        check("post_busy", 64'(o_busy), 0);
        run("enc80_after_rst", 1'b0, k1, 1'b0, 1'b0, 1'b0);

        sel = 2;
        run("enc_r1", 1'b0, k3, 1'b0, 1'b0, 1'b0);
        run("dec_r1", 1'b1, k3, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/boron_key_schedule.md
# boron_key_schedule

Iterative BORON round-key generator for the cipher datapath, supporting both encryption order and decryption order. Loads a master key, steps the key register one round per accepted output, and presents 64-bit round keys over a valid/ready stream. In decryption mode it first walks the key forward to the final round, then emits keys in reverse using the inverse step.

## Interface
- KEY_W, 80, master key width; legal values 80 or 128.
- ROUNDS, 25, number of cipher rounds; legal range 1..31. ROUNDS+1 round keys are emitted.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a schedule; sampled only in IDLE.
- mode  input  1  0 = encryption order, 1 = decryption order; sampled with start.
- key_in  input  KEY_W  master key; sampled with start.
- rk_ready  input  1  downstream accepts rk_out this cycle.
- rk_valid  output  1  rk_out and rk_round are valid.
- rk_out  output  64  round key, equal to K[63:0] of the current key register.
- rk_round  output  5  index i of rk_out (RK_i).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last key is accepted.

## Operation
- Forward step F(K, r), for r = 1..ROUNDS:
  - rotate K left by 13 over KEY_W bits;
  - replace [3:0] with S([3:0]);
  - for KEY_W = 128, also replace [7:4] with S([7:4]);
  - XOR [63:59] with r[4:0].
- K_0 = key_in, K_i = F(K_{i-1}, i), RK_i = K_i[63:0].
- Inverse step G(K, r):
  - XOR [63:59] with r[4:0];
  - apply S⁻¹ to [3:0], and for KEY_W = 128 also to [7:4];
  - rotate right by 13.
  - G(F(K, r), r) = K is mandatory.
- S and S⁻¹ are the codebase's existing forward and inverse BORON 4-bit S-box modules, instantiated twice each for the 128-bit case.
- State machine: IDLE, EXPAND, EMIT, FIN.
  - IDLE:
    - start=1 loads key_in into the key register, latches mode and sets rnd=0.
    - mode=0 goes to EMIT. mode=1 goes to EXPAND.
  - EXPAND (decryption only):
    - applies F with r = rnd+1 each cycle and increments rnd.
    - After ROUNDS cycles rnd=ROUNDS; go to EMIT.
    - rk_valid stays low in this state.
  - EMIT:
    - rk_valid=1 and rk_round=rnd.
    - On rk_valid&&rk_ready:
      - if the last key was sent (enc rnd=ROUNDS, dec rnd=0), go to FIN;
      - else enc: K←F(K, rnd+1), rnd++; dec: K←G(K, rnd), rnd--.
  - FIN: done=1 for one cycle, then IDLE.
- Stall: while rk_valid && !rk_ready, rk_out, rk_round and the key register hold unchanged.
- start while busy is ignored; key_in and mode changes while busy have no effect.
- Reset, asserted at any time including mid-schedule: state=IDLE, key register=0, rnd=0. Outputs rk_valid=0, rk_out=0, rk_round=0, busy=0, done=0. No partial output follows reset release.

## Timing
- All state changes on the rising edge of clk. Reset acts immediately and asynchronously.
- Encryption: RK_0 valid in the cycle after start is sampled. With rk_ready held high, one key per cycle; RK_ROUNDS is valid at cycle ROUNDS+1 after start.
- Decryption: RK_ROUNDS valid ROUNDS+1 cycles after start (ROUNDS EXPAND cycles plus one). Then one key per cycle with rk_ready high.
- done is asserted in the cycle after the final handshake. busy falls in the same cycle that done falls. A new start is accepted in the cycle after done, when state is IDLE again.
- Outputs are registered; there is no combinational path from rk_ready to rk_out.

## Test plan
- Enc, KEY_W=80, key_in=0, rk_ready=1:
  - RK_0 = 64'h0 with rk_round=0;
  - RK_1 = 64'h0800_0000_0000_000X, where X = S(0), with rk_round=1;
  - exactly 26 handshakes, then a done pulse.
- Round-trip, KEY_W=80 and KEY_W=128, random key: capture the enc sequence RK_0..RK_25. The dec run must emit exactly the reversed sequence, with rk_round counting 25 down to 0. The first dec key must appear 26 cycles after start.
- Backpressure: toggle rk_ready pseudo-randomly. rk_out and rk_round must stay stable while stalled, and no key may be skipped or duplicated relative to the rk_ready=1 run.
- start pulsed during EXPAND and during EMIT with a different key_in and mode: output sequence unchanged, and only one done pulse.
- rst driven low mid-EMIT (rk_round=7): all outputs go to 0 immediately. After release the block stays idle until start, then a fresh run matches the reference sequence.
- ROUNDS=1 instance, both modes: enc emits RK_0, RK_1; dec emits RK_1, RK_0; done follows each run.
